mux_sel_arbiter: RTL

Two-requester round-robin arbiter that drives the SEL input of the 2:1 mux stage directly downstream. It decides which source, A or B, owns the mux path. It raises a one-hot grant to the winning requester and limits how long one owner can hold the path while the other is waiting. Every output is registered, so SEL changes only on a clock edge and never glitches into the mux.

---
 rtl/mux_sel_pkg.sv | 14 +
 rtl/hold_counter.sv | 42 ++++
 rtl/mux_sel_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mux_sel_pkg.sv
// Shared definitions for the mux select arbiter: FSM state encoding and the
// SEL values that steer the downstream 2:1 mux.
package mux_sel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } arb_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : mux_sel_pkg

// File: rtl/hold_counter.sv
// Counts how many consecutive cycles the current owner has held the mux path.
// LOAD starts a fresh grant at 1; EN advances the count and sticks at MAX_HOLD.
module hold_counter #(
    parameter int MAX_HOLD = 4,
    localparam int W       = $clog2(MAX_HOLD + 1)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         LOAD,
    input  logic         EN,
    output logic [W-1:0] CNT,
    output logic         AT_MAX
);

    localparam logic [W-1:0] MAX_VAL = W'(MAX_HOLD);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: a new grant wins over an increment; the increment saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (LOAD) begin
            cnt_d = W'(1);
        end else if (EN && (cnt_q != MAX_VAL)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register, cleared by synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CNT    = cnt_q;
    assign AT_MAX = (cnt_q == MAX_VAL);

endmodule : hold_counter

// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter driving the SEL line of a 2:1 mux.
// All outputs come straight from flops so SEL and the grants only move on a
// clock edge. A fair tie-break uses the last granted side, and an owner that
// has held the path for MAX_HOLD cycles yields to a waiting requester.
module mux_sel_arbiter
    import mux_sel_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic REQ_A,
    input  logic REQ_B,
    input  logic DONE,
    output logic SEL,
    output logic GNT_A,
    output logic GNT_B,
    output logic BUSY
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_q;
    logic       last_d;
    logic       sel_q;
    logic       sel_d;
    logic       gnt_a_q;
    logic       gnt_b_q;
    logic       busy_q;

    logic          hold_load;
    logic          hold_en;
    logic          hold_at_max;
    logic [CW-1:0] hold_cnt;
    logic          hold_full;

    hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .CLK    (CLK),
        .RST    (RST),
        .LOAD   (hold_load),
        .EN     (hold_en),
        .CNT    (hold_cnt),
        .AT_MAX (hold_at_max)
    );

    // A count of zero only exists straight after reset, before any grant,
    // so requiring a nonzero count keeps preemption tied to a live grant.
    assign hold_full = hold_at_max && (hold_cnt != '0);

    // Next-state decision, counter control, LAST and SEL bookkeeping.
    always_comb begin
        state_d   = state_q;
        hold_load = 1'b0;
        hold_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (REQ_A && REQ_B) begin
                    state_d = (last_q == SEL_A) ? OWN_B : OWN_A;
                end else if (REQ_A) begin
                    state_d = OWN_A;
                end else if (REQ_B) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                if (DONE || !REQ_A) begin
                    state_d = REQ_B ? OWN_B : IDLE;
                end else if (hold_full && REQ_B) begin
                    state_d = OWN_B;
                end else begin
                    hold_en = 1'b1;
                end
            end
            OWN_B: begin
                if (DONE || !REQ_B) begin
                    state_d = REQ_A ? OWN_A : IDLE;
                end else if (hold_full && REQ_A) begin
                    state_d = OWN_A;
                end else begin
                    hold_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Any entry into an ownership state starts a fresh grant.
        hold_load = ((state_d == OWN_A) && (state_q != OWN_A)) ||
                    ((state_d == OWN_B) && (state_q != OWN_B));

        last_d = last_q;
        sel_d  = sel_q;
        if (state_d == OWN_A) begin
            sel_d = SEL_A;
        end else if (state_d == OWN_B) begin
            sel_d = SEL_B;
        end
        if (hold_load) begin
            last_d = sel_d;
        end
    end

    // State, round-robin memory and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            last_q  <= SEL_B;
            sel_q   <= SEL_A;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt_a_q <= (state_d == OWN_A);
            gnt_b_q <= (state_d == OWN_B);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign SEL   = sel_q;
    assign GNT_A = gnt_a_q;
    assign GNT_B = gnt_b_q;
    assign BUSY  = busy_q;

endmodule : mux_sel_arbiter
